// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter.
//   arb_state_e : arbiter FSM states
//   op_e        : queued command type
//   chan_ctl_t  : per-channel control slot (pending flag + op). The
//                 width-dependent fields (addr/data/byte_en) live beside it
//                 in the arbiter because they follow module parameters.
//   idx_width() : index width for a given channel count (at least 1 bit)
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } arb_state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    typedef struct packed {
        logic pending;
        op_e  op;
    } chan_ctl_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_select.sv
// Combinational winner selection for the port arbiter.
//   pending     : per-channel pending requests
//   last        : index of the most recently granted channel
//   round_robin : 1 = first pending after 'last' (wrapping), 0 = lowest index
//   onehot      : winner as a one-hot vector (all zero when nothing pending)
//   index       : winner index (0 when nothing pending)
//   valid       : at least one channel pending
module rr_select #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic [NUM_PORTS-1:0] pending,
    input  logic [IDX_WIDTH-1:0] last,
    input  logic                 round_robin,
    output logic [NUM_PORTS-1:0] onehot,
    output logic [IDX_WIDTH-1:0] index,
    output logic                 valid
);

    int unsigned          cand;
    logic [IDX_WIDTH-1:0] cand_idx;

    always_comb begin
        index    = '0;
        onehot   = '0;
        cand     = 0;
        cand_idx = '0;
        valid    = |pending;
        // Scan from the farthest candidate down to the nearest so the last
        // hit standing is the highest-priority one.
        for (int unsigned k = NUM_PORTS; k > 0; k--) begin
            if (round_robin) begin
                cand = 32'(last) + k;
                if (cand >= NUM_PORTS) begin
                    cand = cand - NUM_PORTS;
                end
            end else begin
                cand = k - 1;
            end
            cand_idx = IDX_WIDTH'(cand);
            if (pending[cand_idx]) begin
                index = cand_idx;
            end
        end
        if (valid) begin
            onehot[index] = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// N-port front end for one SDRAM controller port.
// Each channel captures a single-cycle read or write request while ready,
// holds it pending, and the arbiter forwards one command at a time to the
// controller (fixed priority or round robin). Read data is held per channel.
//   clk, reset                     : clock, synchronous active-high reset
//   c_addr/c_data/c_byte_en        : per-channel command fields (flattened)
//   c_wr_req/c_rd_req              : per-channel request strobes
//   c_ready                        : channel can accept a request
//   c_q                            : last read data per channel (flattened)
//   m_addr/m_data/m_byte_en        : granted command fields to controller
//   m_wr_req/m_rd_req              : single-cycle command strobes
//   m_ready, m_q                   : controller idle flag and read data
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned ADDR_WIDTH  = 25,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned Q_WIDTH     = 128,
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       c_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]       c_data,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   c_byte_en,
    input  logic [NUM_PORTS-1:0]                  c_wr_req,
    input  logic [NUM_PORTS-1:0]                  c_rd_req,
    output logic [NUM_PORTS-1:0]                  c_ready,
    output logic [NUM_PORTS*Q_WIDTH-1:0]          c_q,
    output logic [ADDR_WIDTH-1:0]                 m_addr,
    output logic [DATA_WIDTH-1:0]                 m_data,
    output logic [DATA_WIDTH/8-1:0]               m_byte_en,
    output logic                                  m_wr_req,
    output logic                                  m_rd_req,
    input  logic                                  m_ready,
    input  logic [Q_WIDTH-1:0]                    m_q
);

    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH = idx_width(NUM_PORTS);

    chan_ctl_t             ctl       [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] slot_addr [NUM_PORTS];
    logic [DATA_WIDTH-1:0] slot_data [NUM_PORTS];
    logic [BE_WIDTH-1:0]   slot_be   [NUM_PORTS];
    logic [Q_WIDTH-1:0]    q_hold    [NUM_PORTS];

    arb_state_e            state;
    logic [IDX_WIDTH-1:0]  last_grant;
    logic [IDX_WIDTH-1:0]  winner;
    logic [NUM_PORTS-1:0]  grant_onehot;

    logic [NUM_PORTS-1:0]  pending_vec;
    logic [NUM_PORTS-1:0]  sel_onehot;
    logic [IDX_WIDTH-1:0]  sel_index;
    logic                  sel_valid;

    always_comb begin
        pending_vec = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            pending_vec[i] = ctl[i].pending;
        end
    end

    always_comb begin
        c_q = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            c_q[i*Q_WIDTH +: Q_WIDTH] = q_hold[i];
        end
    end

    rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_select (
        .pending     (pending_vec),
        .last        (last_grant),
        .round_robin (ROUND_ROBIN != 0),
        .onehot      (sel_onehot),
        .index       (sel_index),
        .valid       (sel_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_grant   <= IDX_WIDTH'(NUM_PORTS - 1);
            winner       <= '0;
            grant_onehot <= '0;
            m_addr       <= '0;
            m_data       <= '0;
            m_byte_en    <= '0;
            m_wr_req     <= 1'b0;
            m_rd_req     <= 1'b0;
            c_ready      <= '1;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                ctl[i]       <= '0;
                slot_addr[i] <= '0;
                slot_data[i] <= '0;
                slot_be[i]   <= '0;
                q_hold[i]    <= '0;
            end
        end else begin
            m_wr_req <= 1'b0;
            m_rd_req <= 1'b0;

            // Capture only into idle slots; a channel being completed this
            // cycle is still not ready, so its request is dropped.
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (c_ready[i] && (c_wr_req[i] || c_rd_req[i])) begin
                    ctl[i].pending <= 1'b1;
                    ctl[i].op      <= c_wr_req[i] ? OP_WR : OP_RD;
                    slot_addr[i]   <= c_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    slot_data[i]   <= c_data[i*DATA_WIDTH +: DATA_WIDTH];
                    slot_be[i]     <= c_byte_en[i*BE_WIDTH +: BE_WIDTH];
                    c_ready[i]     <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (sel_valid && m_ready) begin
                        winner       <= sel_index;
                        grant_onehot <= sel_onehot;
                        last_grant   <= sel_index;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    m_addr    <= slot_addr[winner];
                    m_data    <= slot_data[winner];
                    m_byte_en <= slot_be[winner];
                    m_wr_req  <= (ctl[winner].op == OP_WR);
                    m_rd_req  <= (ctl[winner].op == OP_RD);
                    state     <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!m_ready) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (m_ready) begin
                        if (ctl[winner].op == OP_RD) begin
                            q_hold[winner] <= m_q;
                        end
                        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                            if (grant_onehot[i]) begin
                                ctl[i].pending <= 1'b0;
                                c_ready[i]     <= 1'b1;
                            end
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Parametrised N-port front end for the SDRAM controller: generalises the controller's fixed two-port request interface to `NUM_PORTS` channels arbitrated onto a single controller port. It latches single-cycle read/write requests per channel, grants one at a time by fixed priority or round robin, and returns per-channel read data and ready. It sits between client logic and one port of `sdram`.

## Interface
- `NUM_PORTS`, 4: client channel count, 2..8.
- `ADDR_WIDTH`, 25: word address width.
- `DATA_WIDTH`, 16: write data width; must be a multiple of 8.
- `Q_WIDTH`, 128: read burst width returned to clients.
- `ROUND_ROBIN`, 1: 1 = round robin, 0 = fixed priority (lowest index wins).
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `c_addr` in NUM_PORTS×ADDR_WIDTH: per-channel address.
- `c_data` in NUM_PORTS×DATA_WIDTH: per-channel write data.
- `c_byte_en` in NUM_PORTS×(DATA_WIDTH/8): per-channel byte enables.
- `c_wr_req` in NUM_PORTS: write request, sampled while channel ready.
- `c_rd_req` in NUM_PORTS: read request, sampled while channel ready.
- `c_ready` out NUM_PORTS: channel idle, able to accept a request.
- `c_q` out NUM_PORTS×Q_WIDTH: last read data per channel, held.
- `m_addr`, `m_data`, `m_byte_en` out: selected command fields to controller.
- `m_wr_req`, `m_rd_req` out 1: single-cycle command strobes.
- `m_ready` in 1: controller idle.
- `m_q` in Q_WIDTH: controller read data, valid when `m_ready` rises after a read.

## Operation
- Per-channel capture: on a cycle with `c_ready[i]`=1 and either req high, store addr/data/byte_en/op in channel slot, set pending; `c_ready[i]` goes 0 next cycle. Requests while `c_ready[i]`=0 are ignored. Both reqs high: write taken, read dropped.
- Capture is single-cycle; later changes on client inputs do not affect the stored command.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: if any pending and `m_ready`=1, select winner, go ISSUE.
- Fixed priority: lowest pending index. Round robin: first pending index strictly after last-granted index, wrapping modulo NUM_PORTS; last-granted resets to NUM_PORTS-1 so channel 0 wins first.
- ISSUE: drive winner's fields on `m_*`, assert exactly one of `m_wr_req`/`m_rd_req` for one cycle; go WAIT_BUSY.
- WAIT_BUSY: wait for `m_ready`=0, then WAIT_DONE.
- WAIT_DONE: on `m_ready`=1: if read, load `m_q` into `c_q[winner]`; clear winner's pending; `c_ready[winner]`=1 next cycle; return IDLE.
- `m_addr`/`m_data`/`m_byte_en` hold the granted command from ISSUE through WAIT_DONE.
- A request arriving on the winner channel in the same cycle its pending clears is not captured (ready still 0).

## Timing
- Reset values: `c_ready` all 1, `c_q` all 0, `m_wr_req`/`m_rd_req` 0, `m_addr`/`m_data`/`m_byte_en` 0, all pending 0, FSM IDLE.
- Reset mid-transaction: all pending discarded, strobes drop in the reset cycle's next edge; no `c_q` update.
- Idle-channel latency: request at edge T -> pending at T+1, ISSUE state at T+2 (`m_*_req` high for cycle T+2..T+3) if `m_ready`=1.
- Completion: `c_ready[i]` rises one cycle after `m_ready` rises; `c_q[i]` valid same cycle.
- Minimum gap between consecutive downstream strobes: 4 cycles.
- `m_ready` low in IDLE: arbitration stalls, pending preserved.

## Structure
- Package `sdram_arb_pkg`: FSM state enum, op enum (OP_RD, OP_WR), per-channel command struct typedef.
- One sub-module: `rr_select` — combinational pending-vector + last-grant -> one-hot/index winner, with mode input for fixed priority.

## Test plan
- Single write: ch0 write addr 0x0322020 data 0x1234 be 3 -> one `m_wr_req` pulse with those fields; `c_ready[0]` low until `m_ready` returns.
- Read-back: ch1 read 0x0322020, controller model returns 128'h…3210_7654 -> `c_q[1]` equals it, `c_q[0]` unchanged.
- Round robin: ch0..ch3 all request same cycle -> grants 0,1,2,3; then ch0 and ch3 again with last=3 -> 0 then 3.
- Fixed priority (`ROUND_ROBIN`=0): ch2 and ch1 pending -> ch1 granted first, ch2 after.
- Boundary: ch0 asserts both reqs -> only write issued; ch0 re-requests while busy -> ignored, one strobe total.
- Reset during WAIT_DONE with ch2 pending -> all `c_ready`=1, no strobes, `c_q` zero after reset.
